// File: rtl/key_event_scheduler.sv
// key_event_scheduler
// Converts the held-key code from the keyboard decoder into discrete
// direction events with typematic auto-repeat, keeps one pending event per
// player and round-robin arbitrates both players onto one valid/ready port.
module key_event_scheduler #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_player,
    output logic [1:0] out_dir,
    output logic       out_repeat,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    // key tracking and repeat FSM
    logic [7:0]       key_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // classified key code
    logic       code_valid_s;
    logic       code_player_s;
    logic [1:0] code_dir_s;
    logic       press_s;

    // event posted this cycle
    logic       post_s;
    logic       post_rep_s;
    logic [1:0] post_hit_s;

    // pending slots, indexed by player
    logic [1:0]      slot_full_q, slot_full_d;
    logic [1:0][1:0] slot_dir_q, slot_dir_d;
    logic [1:0]      slot_rep_q, slot_rep_d;

    // output stage and arbitration
    logic [1:0] grant_s;
    logic       load_s;
    logic       last_grant_q, last_grant_d;
    logic       out_valid_q, out_valid_d;
    logic       out_player_q, out_player_d;
    logic [1:0] out_dir_q, out_dir_d;
    logic       out_repeat_q, out_repeat_d;
    logic       overflow_q, overflow_d;

    // Decode the raw key code into validity, owning player and direction.
    always_comb begin
        code_valid_s  = 1'b1;
        code_player_s = 1'b0;
        code_dir_s    = 2'd0;
        case (key_code)
            8'd1:    begin code_player_s = 1'b0; code_dir_s = 2'd0; end
            8'd2:    begin code_player_s = 1'b0; code_dir_s = 2'd1; end
            8'd3:    begin code_player_s = 1'b0; code_dir_s = 2'd2; end
            8'd4:    begin code_player_s = 1'b0; code_dir_s = 2'd3; end
            8'd5:    begin code_player_s = 1'b1; code_dir_s = 2'd0; end
            8'd6:    begin code_player_s = 1'b1; code_dir_s = 2'd1; end
            8'd7:    begin code_player_s = 1'b1; code_dir_s = 2'd2; end
            8'd8:    begin code_player_s = 1'b1; code_dir_s = 2'd3; end
            default: code_valid_s = 1'b0;
        endcase
        // A change straight from one valid key to another is also a press.
        press_s = code_valid_s && (key_code != key_q);
    end

    // Repeat FSM: initial event on press, first repeat after the delay,
    // further repeats every period; release or invalid code goes idle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        post_s     = 1'b0;
        post_rep_s = 1'b0;
        if (!code_valid_s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else if (press_s) begin
            post_s  = 1'b1;
            state_d = ST_DELAY;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_DELAY: begin
                    if (cnt_q == DELAY_LAST) begin
                        post_s     = 1'b1;
                        post_rep_s = 1'b1;
                        state_d    = ST_REPEAT;
                        cnt_d      = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (cnt_q == PERIOD_LAST) begin
                        post_s     = 1'b1;
                        post_rep_s = 1'b1;
                        cnt_d      = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
        post_hit_s = post_s ? (code_player_s ? 2'b10 : 2'b01) : 2'b00;
    end

    // Round-robin grant into the output stage whenever it is free or draining.
    always_comb begin
        grant_s = 2'b00;
        load_s  = !out_valid_q || out_ready;
        if (load_s) begin
            if (slot_full_q == 2'b11) begin
                if (last_grant_q) begin
                    grant_s = 2'b01;
                end else begin
                    grant_s = 2'b10;
                end
            end else if (slot_full_q[0]) begin
                grant_s = 2'b01;
            end else if (slot_full_q[1]) begin
                grant_s = 2'b10;
            end else begin
                grant_s = 2'b00;
            end
        end else begin
            grant_s = 2'b00;
        end
    end

    // Slot update: a grant empties a slot, a post fills it; a post onto a
    // full, ungranted slot replaces the old event and flags overflow.
    always_comb begin
        slot_full_d = slot_full_q & ~grant_s;
        slot_dir_d  = slot_dir_q;
        slot_rep_d  = slot_rep_q;
        for (int p = 0; p < 2; p++) begin
            if (post_hit_s[p]) begin
                slot_full_d[p] = 1'b1;
                slot_dir_d[p]  = code_dir_s;
                slot_rep_d[p]  = post_rep_s;
            end else begin
                slot_full_d[p] = slot_full_q[p] & ~grant_s[p];
            end
        end
        overflow_d = |(post_hit_s & slot_full_q & ~grant_s);
    end

    // Output stage next state: load the granted slot, otherwise hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_player_d = out_player_q;
        out_dir_d    = out_dir_q;
        out_repeat_d = out_repeat_q;
        last_grant_d = last_grant_q;
        if (grant_s[1]) begin
            out_valid_d  = 1'b1;
            out_player_d = 1'b1;
            out_dir_d    = slot_dir_q[1];
            out_repeat_d = slot_rep_q[1];
            last_grant_d = 1'b1;
        end else if (grant_s[0]) begin
            out_valid_d  = 1'b1;
            out_player_d = 1'b0;
            out_dir_d    = slot_dir_q[0];
            out_repeat_d = slot_rep_q[0];
            last_grant_d = 1'b0;
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset drops every pending and in-flight event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q        <= 8'd0;
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            slot_full_q  <= 2'b00;
            slot_dir_q   <= '0;
            slot_rep_q   <= 2'b00;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_player_q <= 1'b0;
            out_dir_q    <= 2'd0;
            out_repeat_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            key_q        <= key_code;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_full_q  <= slot_full_d;
            slot_dir_q   <= slot_dir_d;
            slot_rep_q   <= slot_rep_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_player_q <= out_player_d;
            out_dir_q    <= out_dir_d;
            out_repeat_q <= out_repeat_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_player = out_player_q;
    assign out_dir    = out_dir_q;
    assign out_repeat = out_repeat_q;
    assign overflow   = overflow_q;

endmodule
